fetch_queue: RTL and testbench

//  Instruction-fetch initiator for the SISC core. Drives the instruction-memory read address,

---
 rtl/sisc_fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_fetch_pkg.sv
// Shared definitions for the SISC instruction-fetch front end: FSM state encoding,
// prefetch entry layout at default widths, and the default reset PC.
package sisc_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fq_state_e;

    localparam int unsigned   AW_DEF       = 16;
    localparam int unsigned   DW_DEF       = 32;
    localparam logic [15:0]   RESET_PC_DEF = 16'h0000;

    // Entry layout: PC in the upper bits, instruction in the lower bits.
    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO: DEPTH entries of W bits, synchronous clear, push/pop, occupancy.
// Head reads as zero when empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 48
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [PW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_f || clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    // Storage needs no reset: occupancy gates the head output.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// SISC instruction-fetch initiator: PC/redirect FSM feeding a prefetch FIFO towards decode.
// Optional FETCH_STATS_EN adds saturating push/flush counters.
module fetch_queue
    import sisc_fetch_pkg::*;
#(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_f,
    output logic [AW-1:0]            im_addr,
    input  logic [DW-1:0]            im_data,
    output logic [DW-1:0]            ins_data,
    output logic [AW-1:0]            ins_pc,
    output logic                     ins_valid,
    input  logic                     ins_ready,
    input  logic                     br_taken,
    input  logic [AW-1:0]            br_addr,
`ifdef FETCH_STATS_EN
    output logic [31:0]              stat_fetched,
    output logic [31:0]              stat_flushed,
`endif
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_e       state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            push, pop;
    logic [CW-1:0]   count;
    logic [AW+DW-1:0] head;

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = br_taken ? S_FLUSH : S_RUN;
            S_RUN:   state_d = br_taken ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = br_taken ? S_FLUSH : S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // A redirect discards the head, so a same-cycle pop is suppressed rather than taken.
    always_comb begin
        pop  = ins_valid && ins_ready && !br_taken;
        push = (state_q == S_RUN) && !br_taken &&
               ((count < CW'(DEPTH)) || pop);
        pc_d = pc_q;
        if (br_taken)  pc_d = br_addr;
        else if (push) pc_d = pc_q + 1'b1;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk     (clk),
        .rst_f   (rst_f),
        .clr_i   (br_taken),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({pc_q, im_data}),
        .dout_o  (head),
        .count_o (count)
    );

    assign im_addr   = pc_q;
    assign ins_valid = (count != '0);
    assign ins_pc    = head[AW+DW-1:DW];
    assign ins_data  = head[DW-1:0];
    assign fq_count  = count;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, flushed_q;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flushed_q} + 33'(count);

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (push && (fetched_q != '1)) fetched_q <= fetched_q + 1'b1;
            if (br_taken) flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); memory returns {16'hA5A5, addr}.
// Define FETCH_STATS_EN to also check the statistics counters.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        br_taken;
    logic [15:0] br_addr;
    logic [2:0]  fq_count;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    assign im_data = {16'hA5A5, im_addr};

    fetch_queue #(
        .DEPTH    (4),
        .AW       (16),
        .DW       (32),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .rst_f        (rst_f),
        .im_addr      (im_addr),
        .im_data      (im_data),
        .ins_data     (ins_data),
        .ins_pc       (ins_pc),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
`ifdef FETCH_STATS_EN
        .stat_fetched (stat_fetched),
        .stat_flushed (stat_flushed),
`endif
        .fq_count     (fq_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_f     = 1'b0;
        ins_ready = 1'b0;
        br_taken  = 1'b0;
        br_addr   = 16'h0000;
        step();
        step();
        chk("rst_valid", 64'(ins_valid), 64'd0);
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_imaddr", 64'(im_addr), 64'h0);
        chk("rst_data", 64'(ins_data), 64'h0);
        chk("rst_pc", 64'(ins_pc), 64'h0);
`ifdef FETCH_STATS_EN
        chk("rst_stat_fetched", 64'(stat_fetched), 64'd0);
        chk("rst_stat_flushed", 64'(stat_flushed), 64'd0);
`endif

        // Streaming with decode always ready: boot idle, push, then one per cycle.
        rst_f     = 1'b1;
        ins_ready = 1'b1;
        step();
        chk("boot_valid", 64'(ins_valid), 64'd0);
        chk("boot_imaddr", 64'(im_addr), 64'h0);
        step();
        chk("first_valid", 64'(ins_valid), 64'd1);
        chk("first_pc", 64'(ins_pc), 64'h0);
        chk("first_data", 64'(ins_data), 64'hA5A5_0000);
        chk("first_count", 64'(fq_count), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stream_pc", 64'(ins_pc), 64'(k));
            chk("stream_data", 64'(ins_data), 64'hA5A5_0000 + 64'(k));
            chk("stream_count", 64'(fq_count), 64'd1);
        end

        // Decode stalled from reset: FIFO fills and fetch stops.
        rst_f     = 1'b0;
        ins_ready = 1'b0;
        step();
        rst_f = 1'b1;
        step();
        repeat (5) step();
        chk("full_count", 64'(fq_count), 64'd4);
        chk("full_imaddr", 64'(im_addr), 64'h4);
        chk("full_pc", 64'(ins_pc), 64'h0);
        chk("full_valid", 64'(ins_valid), 64'd1);
        step();
        chk("full_pc_stable", 64'(ins_pc), 64'h0);
        chk("full_count_stable", 64'(fq_count), 64'd4);

        // One-cycle accept on a full FIFO: pop and push on the same edge.
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        chk("pp_pc", 64'(ins_pc), 64'h1);
        chk("pp_count", 64'(fq_count), 64'd4);
        chk("pp_imaddr", 64'(im_addr), 64'h5);
        step();
        chk("pp_hold_pc", 64'(ins_pc), 64'h1);
        chk("pp_hold_imaddr", 64'(im_addr), 64'h5);

        // Mid-stream reset pulse with a full FIFO.
        rst_f = 1'b0;
        step();
        rst_f = 1'b1;
        chk("midrst_valid", 64'(ins_valid), 64'd0);
        chk("midrst_count", 64'(fq_count), 64'd0);
        chk("midrst_imaddr", 64'(im_addr), 64'h0);
        chk("midrst_pc", 64'(ins_pc), 64'h0);

        // Redirect with three entries queued.
        step();
        repeat (3) step();
        chk("pre_br_count", 64'(fq_count), 64'd3);
        chk("pre_br_imaddr", 64'(im_addr), 64'h3);
        chk("pre_br_pc", 64'(ins_pc), 64'h0);
        br_taken = 1'b1;
        br_addr  = 16'h0100;
        step();
        br_taken = 1'b0;
        chk("br_count", 64'(fq_count), 64'd0);
        chk("br_valid", 64'(ins_valid), 64'd0);
        chk("br_imaddr", 64'(im_addr), 64'h0100);
        step();
        chk("bubble_valid", 64'(ins_valid), 64'd0);
        chk("bubble_imaddr", 64'(im_addr), 64'h0100);
        step();
        chk("redir_valid", 64'(ins_valid), 64'd1);
        chk("redir_pc", 64'(ins_pc), 64'h0100);
        chk("redir_data", 64'(ins_data), 64'hA5A5_0100);
        chk("redir_count", 64'(fq_count), 64'd1);
        chk("redir_imaddr", 64'(im_addr), 64'h0101);
`ifdef FETCH_STATS_EN
        chk("stat_fetched", 64'(stat_fetched), 64'd4);
        chk("stat_flushed", 64'(stat_flushed), 64'd3);
`endif

        // Redirect near the top of the address space; same-cycle pop is discarded.
        ins_ready = 1'b1;
        br_taken  = 1'b1;
        br_addr   = 16'hFFFE;
        step();
        br_taken = 1'b0;
        chk("wrap_br_valid", 64'(ins_valid), 64'd0);
        chk("wrap_br_count", 64'(fq_count), 64'd0);
        step();
        chk("wrap_bubble_imaddr", 64'(im_addr), 64'hFFFE);
        step();
        chk("wrap_pc0", 64'(ins_pc), 64'hFFFE);
        step();
        chk("wrap_pc1", 64'(ins_pc), 64'hFFFF);
        step();
        chk("wrap_pc2", 64'(ins_pc), 64'h0000);
        chk("wrap_data2", 64'(ins_data), 64'hA5A5_0000);
        step();
        chk("wrap_pc3", 64'(ins_pc), 64'h0001);
        chk("wrap_data3", 64'(ins_data), 64'hA5A5_0001);
`ifdef FETCH_STATS_EN
        chk("stat_flushed_pop", 64'(stat_flushed), 64'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
